// File: rtl/result_pipe_if.sv
// Data-memory request/response bus between the result pipeline and data memory.
interface result_pipe_if;
    localparam int unsigned XLEN = 32;

    logic            dmem_re;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;

    // Pipeline side issues requests and consumes read data / completion.
    modport master (
        output dmem_re, dmem_we, dmem_addr, dmem_wdata,
        input  mem_rdata, mem_ready
    );

    // Memory side serves requests.
    modport slave (
        input  dmem_re, dmem_we, dmem_addr, dmem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/result_pipe.sv
// EX/MEM and MEM/WB result pipeline with data-memory stall, load-use detect
// and write-back port. Optional performance counters: RESULT_PIPE_PERF_CNT_EN.
module result_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_RegWrite,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    result_pipe_if.master dmem,
    output logic        EX_MEM_RegWrite,
    output logic [4:0]  EX_MEM_rd,
    output logic [31:0] EX_MEM_alu_result,
    output logic        MEM_WB_RegWrite,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pipe_stall,
    output logic        load_use_stall,
    output logic [31:0] retired_cnt,
    output logic [31:0] lu_stall_cnt
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    logic            ex_mem_valid;
    logic            ex_mem_memread;
    logic            ex_mem_memwrite;
    logic [XLEN-1:0] ex_mem_store_data;
    logic            mem_wait;

    // A pending memory access that has not completed freezes EX/MEM.
    assign mem_wait   = ex_mem_valid & (ex_mem_memread | ex_mem_memwrite) & ~dmem.mem_ready;
    assign pipe_stall = mem_wait;

    // Load in EX whose destination feeds the instruction in ID.
    assign load_use_stall = ex_valid & ex_MemRead & (ex_rd != RW'(0)) &
                            ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // EX/MEM stage register: capture EX results unless memory is stalling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_valid      <= 1'b0;
            EX_MEM_RegWrite   <= 1'b0;
            ex_mem_memread    <= 1'b0;
            ex_mem_memwrite   <= 1'b0;
            EX_MEM_rd         <= '0;
            EX_MEM_alu_result <= '0;
            ex_mem_store_data <= '0;
        end else if (!mem_wait) begin
            ex_mem_valid      <= ex_valid;
            EX_MEM_RegWrite   <= ex_valid & ex_RegWrite & (ex_rd != RW'(0));
            ex_mem_memread    <= ex_MemRead;
            ex_mem_memwrite   <= ex_MemWrite;
            EX_MEM_rd         <= ex_rd;
            EX_MEM_alu_result <= ex_alu_result;
            ex_mem_store_data <= ex_store_data;
        end
    end

    // MEM/WB stage register: advance result, or insert a bubble while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MEM_WB_RegWrite <= 1'b0;
            MEM_WB_rd       <= '0;
            MEM_WB_wdata    <= '0;
        end else if (mem_wait) begin
            MEM_WB_RegWrite <= 1'b0;
            MEM_WB_rd       <= '0;
            MEM_WB_wdata    <= '0;
        end else begin
            MEM_WB_RegWrite <= EX_MEM_RegWrite;
            MEM_WB_rd       <= EX_MEM_rd;
            MEM_WB_wdata    <= ex_mem_memread ? dmem.mem_rdata : EX_MEM_alu_result;
        end
    end

    // Memory request straight from the frozen EX/MEM contents.
    assign dmem.dmem_re    = ex_mem_valid & ex_mem_memread;
    assign dmem.dmem_we    = ex_mem_valid & ex_mem_memwrite;
    assign dmem.dmem_addr  = EX_MEM_alu_result;
    assign dmem.dmem_wdata = ex_mem_store_data;

    // Register-file write port is MEM/WB itself.
    assign rf_we    = MEM_WB_RegWrite;
    assign rf_waddr = MEM_WB_rd;
    assign rf_wdata = MEM_WB_wdata;

`ifdef RESULT_PIPE_PERF_CNT_EN
    logic [XLEN-1:0] retired_q;
    logic [XLEN-1:0] lu_stall_q;

    // Retired write-backs and load-use stall cycles, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q  <= '0;
            lu_stall_q <= '0;
        end else begin
            if (MEM_WB_RegWrite) retired_q  <= retired_q + XLEN'(1);
            if (load_use_stall)  lu_stall_q <= lu_stall_q + XLEN'(1);
        end
    end

    assign retired_cnt  = retired_q;
    assign lu_stall_cnt = lu_stall_q;
`else
    assign retired_cnt  = '0;
    assign lu_stall_cnt = '0;
`endif
endmodule

// File: doc/result_pipe.md
RESULT_PIPE -- requirements
Module: result_pipe

Interface
REQ-001 SHALL provide: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite  in  1 each  EX-stage instruction controls.
REQ-004 SHALL provide: ex_rd  in  5; ex_alu_result, ex_store_data  in  32 each  EX-stage destination and values.
REQ-005 SHALL provide: id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL provide: mem_rdata  in  32; mem_ready  in  1  data-memory read data and access-complete.
REQ-007 SHALL provide: dmem_re, dmem_we  out  1; dmem_addr, dmem_wdata  out  32  data-memory request.
REQ-008 SHALL provide: EX_MEM_RegWrite  out  1; EX_MEM_rd  out  5; EX_MEM_alu_result  out  32  forwarding sources, EX/MEM.
REQ-009 SHALL provide: MEM_WB_RegWrite  out  1; MEM_WB_rd  out  5; MEM_WB_wdata  out  32  forwarding sources, MEM/WB.
REQ-010 SHALL provide: rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  register-file write port.
REQ-011 SHALL provide: pipe_stall, load_use_stall  out  1 each  upstream hold requests.
REQ-012 SHALL provide: retired_cnt, lu_stall_cnt  out  32 each  performance counters (see Configuration).

Function
REQ-013 SHALL hold two register stages, EX/MEM (valid, RegWrite, MemRead, MemWrite, rd, alu_result, store_data) and MEM/WB (RegWrite, rd, wdata).
REQ-014 SHALL compute mem_wait = EX_MEM valid AND (MemRead OR MemWrite) AND NOT mem_ready; pipe_stall = mem_wait, combinational.
REQ-015 SHALL, when mem_wait=0, capture EX/MEM from ex_* each edge; valid = ex_valid; RegWrite = ex_valid AND ex_RegWrite AND (ex_rd != 0).
REQ-016 SHALL, when mem_wait=0, capture MEM/WB from EX/MEM: RegWrite = EX/MEM RegWrite, rd copied, wdata = mem_rdata if MemRead else alu_result.
REQ-017 SHALL, when mem_wait=1, hold EX/MEM unchanged and load MEM/WB with a bubble (RegWrite=0, rd=0, wdata=0); ex_* ignored that cycle.
REQ-018 SHALL drive dmem_re = EX/MEM valid AND MemRead, dmem_we = EX/MEM valid AND MemWrite, dmem_addr = alu_result, dmem_wdata = store_data, held stable while mem_wait=1.
REQ-019 SHALL drive rf_we/rf_waddr/rf_wdata directly from MEM_WB_RegWrite/MEM_WB_rd/MEM_WB_wdata (one-cycle write-back, no extra latency).
REQ-020 SHALL assert load_use_stall combinationally when ex_valid AND ex_MemRead AND ex_rd != 0 AND (ex_rd == id_rs1 OR ex_rd == id_rs2).
REQ-021 SHALL give latency: EX capture to rf_we = 2 edges with mem_ready high; each mem_ready-low cycle adds one.
REQ-022 SHALL never assert RegWrite at either stage for rd = 0, including loads to x0.
REQ-023 SHALL treat simultaneous load_use_stall and pipe_stall independently; pipe_stall has priority for EX/MEM hold.

Reset
REQ-024 SHALL on reset clear all EX/MEM and MEM/WB fields to 0, immediately and independent of clk.
REQ-025 SHALL therefore drive rf_we, dmem_re, dmem_we, pipe_stall, both RegWrite outputs, and counters 0 during reset.
REQ-026 SHALL on reset mid-access abandon the pending memory access; no write-back of it occurs after release.

Configuration
REQ-027 SHALL compile performance counters only when macro RESULT_PIPE_PERF_CNT_EN is defined.
REQ-028 SHALL with the macro: retired_cnt += 1 on each edge with rf_we=1; lu_stall_cnt += 1 on each edge with load_use_stall=1; both wrap modulo 2^32.
REQ-029 SHALL without the macro: tie retired_cnt and lu_stall_cnt to 0, no counter flops.

Verification
REQ-030 SHALL test ALU op: ex_valid=1, RegWrite=1, rd=5, alu_result=0x1234 -> EX_MEM_rd=5 after edge 1; rf_we=1, rf_waddr=5, rf_wdata=0x1234 after edge 2.
REQ-031 SHALL test load with 2 wait cycles: MemRead, rd=7, addr=0x100, mem_ready low 2 cycles then high with mem_rdata=0xCAFE -> pipe_stall=1 two cycles, MEM/WB bubbles, then rf_wdata=0xCAFE to x7.
REQ-032 SHALL test load-use: ex_MemRead=1, ex_rd=3, id_rs2=3 -> load_use_stall=1; ex_rd=0 -> load_use_stall=0.
REQ-033 SHALL test x0 write: RegWrite=1, rd=0, alu_result=0xFFFF -> EX_MEM_RegWrite=0, rf_we never asserted.
REQ-034 SHALL test reset asserted mid-stall (mem_ready=0, store pending) -> all outputs 0 asynchronously; after release, no dmem_we and no rf_we.
REQ-035 SHALL test, with RESULT_PIPE_PERF_CNT_EN, three back-to-back ALU writes -> retired_cnt=3; without macro -> retired_cnt=0.
